alu_arbiter: RTL

Shares one `alu_top` datapath among `NUM_REQ` independent requesters. The block accepts one operation at a time from round-robin-selected requesters and drives the ALU's operand/operator/`op_valid` inputs. It then waits for `operation_done` and routes `result` back to the requester that issued the operation. It sits between the testbench/transactor side (multiple operation sources) and the single `alu_top` instance.

---
 rtl/alu_arb_pkg.sv | 28 ++
 rtl/alu_arb_rr_pick.sv | 33 +++
 rtl/alu_arbiter.sv | 127 ++++++++++++
 3 files changed

// File: rtl/alu_arb_pkg.sv
// alu_arbiter shared definitions: FSM encoding, default widths,
// timeout counter width and the round-robin wrap helper.
package alu_arb_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_WAIT    = 2'd2,
    S_RESPOND = 2'd3
  } state_t;

  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_DATA_W  = 32;
  localparam int DEF_OP_W    = 8;
  localparam int DEF_TIMEOUT = 64;

  // TIMEOUT_CYCLES must fit in this many bits
  localparam int TMO_CNT_W = 16;

  function automatic int rr_next(
    input int base,
    input int off,
    input int n
  );
    return (base + off) % n;
  endfunction

endpackage

// File: rtl/alu_arb_rr_pick.sv
// Combinational round-robin picker: first set request bit
// searching upward from ptr+1, wrapping to 0.
module alu_arb_rr_pick
  import alu_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int IW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IW-1:0]      idx,
  output logic               any
);

  int j;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    j     = 0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      j = rr_next(int'(ptr), i, NUM_REQ);
      if (!any && req[j]) begin
        any      = 1'b1;
        grant[j] = 1'b1;
        idx      = IW'(j);
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU among NUM_REQ requesters.
// Optional WAIT timeout enabled by defining ALU_ARB_TIMEOUT_EN.
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int NUM_REQ        = DEF_NUM_REQ,
  parameter int DATA_W         = DEF_DATA_W,
  parameter int OP_W           = DEF_OP_W,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_operand_a,
  input  logic [NUM_REQ*DATA_W-1:0] req_operand_b,
  input  logic [NUM_REQ*OP_W-1:0]   req_operator,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_result,
  output logic                      rsp_error,
  output logic [DATA_W-1:0]         alu_operand_a,
  output logic [DATA_W-1:0]         alu_operand_b,
  output logic [OP_W-1:0]           alu_operator,
  output logic                      alu_op_valid,
  input  logic                      alu_operation_done,
  input  logic [DATA_W-1:0]         alu_result,
  output logic                      busy
);

  localparam int IW = $clog2(NUM_REQ);

  state_t               state;
  logic [IW-1:0]        ptr;
  logic [IW-1:0]        gnt;
  logic [NUM_REQ-1:0]   pick_grant;
  logic [IW-1:0]        pick_idx;
  logic                 pick_any;

  alu_arb_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IW      (IW)
  ) u_pick (
    .req   (req_valid),
    .ptr   (ptr),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  assign req_ready = (state == S_IDLE) ? pick_grant : '0;
  assign busy      = (state != S_IDLE);

`ifdef ALU_ARB_TIMEOUT_EN
  localparam logic [TMO_CNT_W-1:0] TMO_LAST =
    TMO_CNT_W'(TIMEOUT_CYCLES - 1);

  logic [TMO_CNT_W-1:0] tmo_cnt;
`else
  // constant 0 for any legal TIMEOUT_CYCLES; no timeout logic
  assign rsp_error = (TIMEOUT_CYCLES < 0);
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= S_IDLE;
      ptr           <= IW'(NUM_REQ - 1);
      gnt           <= '0;
      alu_operand_a <= '0;
      alu_operand_b <= '0;
      alu_operator  <= '0;
      alu_op_valid  <= 1'b0;
      rsp_valid     <= '0;
      rsp_result    <= '0;
`ifdef ALU_ARB_TIMEOUT_EN
      rsp_error     <= 1'b0;
      tmo_cnt       <= '0;
`endif
    end else begin
      alu_op_valid <= 1'b0;
      rsp_valid    <= '0;
`ifdef ALU_ARB_TIMEOUT_EN
      rsp_error    <= 1'b0;
`endif
      unique case (state)
        S_IDLE: begin
          if (pick_any) begin
            gnt           <= pick_idx;
            alu_operand_a <= req_operand_a[pick_idx*DATA_W +: DATA_W];
            alu_operand_b <= req_operand_b[pick_idx*DATA_W +: DATA_W];
            alu_operator  <= req_operator[pick_idx*OP_W +: OP_W];
            alu_op_valid  <= 1'b1;
            state         <= S_ISSUE;
          end
        end
        S_ISSUE: begin
`ifdef ALU_ARB_TIMEOUT_EN
          tmo_cnt <= '0;
`endif
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (alu_operation_done) begin
            rsp_result     <= alu_result;
            rsp_valid[gnt] <= 1'b1;
            state          <= S_RESPOND;
          end
`ifdef ALU_ARB_TIMEOUT_EN
          else if (tmo_cnt == TMO_LAST) begin
            rsp_result     <= '0;
            rsp_error      <= 1'b1;
            rsp_valid[gnt] <= 1'b1;
            state          <= S_RESPOND;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
`endif
        end
        S_RESPOND: begin
          ptr   <= gnt;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
